alu_issue_stage: RTL

Decode/issue pipeline stage that drives the integer ALU's operand and control inputs. It accepts one instruction word per handshake and decodes the OP, OP-IMM, LUI and AUIPC opcodes. It selects the two 32-bit operands, generates the 4-bit ALU control code, and holds everything in an output register with valid/ready backpressure and flush. It sits between fetch/register-read and the ALU/execute stage.

---
 rtl/alu_issue_if.sv | 34 +++
 rtl/alu_issue_stage.sv | 135 +++++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// Handshake and payload bundle between upstream (fetch/register-read),
// the ALU issue stage, and the execute stage.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [3:0]  out_alu_ctrl;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_illegal;
  logic [31:0] issue_count;

  // Issue stage side.
  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_alu_ctrl, out_rd,
    output out_rd_we, out_illegal, issue_count
  );

  // Environment side: drives instructions in and consumes decoded ops.
  modport master (
    output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, flush, out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_alu_ctrl, out_rd,
    input  out_rd_we, out_illegal, issue_count
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU decode/issue stage: decodes OP, OP-IMM, LUI and AUIPC into ALU
// operands and a 4-bit control code, held in a single output register
// with valid/ready backpressure, flush and a completed-issue counter.
module alu_issue_stage (
  input logic        clk,
  input logic        rst,
  alu_issue_if.slave bus
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } issue_t;

  issue_t      dec;
  issue_t      held;
  logic        legal;
  logic        out_valid_q;
  logic [31:0] count_q;
  logic        load;
  logic        consume;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = bus.in_instr[6:0];
  assign funct3 = bus.in_instr[14:12];
  assign funct7 = bus.in_instr[31:25];

  // Decode the incoming word into operands, control code and legality.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    dec   = '0;
    legal = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        legal    = (funct7 == F7_BASE) ||
                   (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
        dec.op1  = bus.in_rs1_data;
        dec.op2  = bus.in_rs2_data;
        dec.ctrl = {bus.in_instr[30], funct3};
      end
      OPC_OPIMM: begin
        dec.op1 = bus.in_rs1_data;
        unique case (funct3)
          3'b001: begin
            legal    = (funct7 == F7_BASE);
            dec.op2  = {27'b0, bus.in_instr[24:20]};
            dec.ctrl = 4'b0001;
          end
          3'b101: begin
            legal    = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            dec.op2  = {27'b0, bus.in_instr[24:20]};
            dec.ctrl = {bus.in_instr[30], 3'b101};
          end
          default: begin
            // instr[30] is immediate data here, not an opcode modifier.
            legal    = 1'b1;
            dec.op2  = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
            dec.ctrl = {1'b0, funct3};
          end
        endcase
      end
      OPC_LUI: begin
        legal   = 1'b1;
        dec.op2 = {bus.in_instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        legal   = 1'b1;
        dec.op1 = bus.in_pc;
        dec.op2 = {bus.in_instr[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase

    // Illegal words are still issued, but as an inert ADD 0,0 with no writeback.
    if (!legal) begin
      dec.op1  = '0;
      dec.op2  = '0;
      dec.ctrl = '0;
    end
    dec.rd      = bus.in_instr[11:7];
    dec.rd_we   = legal && (bus.in_instr[11:7] != 5'd0);
    dec.illegal = !legal;
  end

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready && !bus.flush;
  assign consume      = out_valid_q && bus.out_ready;

  // Output register and issue counter; flush outranks load and consume.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      out_valid_q <= 1'b0;
      held        <= '0;
      count_q     <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else begin
      if (consume) begin
        count_q <= count_q + 32'd1;
      end
      if (load) begin
        held        <= dec;
        out_valid_q <= 1'b1;
      end else if (consume) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_op1      = held.op1;
  assign bus.out_op2      = held.op2;
  assign bus.out_alu_ctrl = held.ctrl;
  assign bus.out_rd       = held.rd;
  assign bus.out_rd_we    = held.rd_we;
  assign bus.out_illegal  = held.illegal;
  assign bus.issue_count  = count_q;

endmodule
